// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP multiply-accumulate slice:
// configuration-bit positions, pipeline latencies and saturation limits.
package dsp_pkg;

  localparam int CFG_INREG  = 0;
  localparam int CFG_SIGNED = 1;
  localparam int CFG_ACC    = 2;
  localparam int CFG_CASC   = 3;
  localparam int CFG_SAT    = 4;
  localparam int CFG_SIMD   = 5;

  localparam int LAT_INREG  = 3;
  localparam int LAT_BYPASS = 2;

  // Largest representable value of a w-bit field (w < 64).
  function automatic logic [63:0] sat_max(input int w, input logic sm);
    return sm ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
  endfunction

  // Smallest representable value of a w-bit field, returned sign-extended to 64 bits.
  function automatic logic [63:0] sat_min(input int w, input logic sm);
    return sm ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/dsp_mac_cascade_if.sv
// Data/control bundle between the tile switch matrix and the MAC slice.
interface dsp_mac_cascade_if #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 20
) ();

  // valid_in qualifies A/B/clr for one cycle; there is no backpressure.
  // ce=0 freezes the whole pipeline. valid_out marks a cycle in which Q
  // was updated by a beat; casc_out always mirrors Q.
  logic                 ce;
  logic                 valid_in;
  logic                 clr;
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic [ACC_WIDTH-1:0] casc_in;
  logic [ACC_WIDTH-1:0] Q;
  logic [ACC_WIDTH-1:0] casc_out;
  logic                 valid_out;
  logic                 overflow;

  modport master (
    output ce, valid_in, clr, A, B, casc_in,
    input  Q, casc_out, valid_out, overflow
  );

  modport slave (
    input  ce, valid_in, clr, A, B, casc_in,
    output Q, casc_out, valid_out, overflow
  );

endinterface

// File: rtl/dsp_mac_lane.sv
// One arithmetic lane: extend and multiply on the S1 side, then the
// accumulate + cascade add with overflow detection and optional clamp.
module dsp_mac_lane
  import dsp_pkg::*;
#(
  parameter int AW = 8,
  parameter int BW = 8,
  parameter int W  = 20
) (
  input  logic          signed_mode,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [W-1:0]  prod,
  input  logic [W-1:0]  prod_reg,
  input  logic [W-1:0]  acc,
  input  logic [W-1:0]  casc,
  input  logic          use_acc,
  input  logic          use_casc,
  input  logic          sat,
  output logic [W-1:0]  sum,
  output logic          ovf
);

  localparam int PW = AW + BW;
  localparam int SW = W + 2;  // three W-bit terms never exceed W+2 bits

  logic [PW-1:0] a_ext, b_ext, p_full;
  logic [SW-1:0] t_acc, t_prod, t_casc, total;
  logic [2:0]    top;

  function automatic logic [SW-1:0] ext(input logic [W-1:0] x, input logic sm);
    return sm ? SW'(signed'(x)) : SW'(x);
  endfunction

  always_comb begin
    a_ext  = signed_mode ? PW'(signed'(a)) : PW'(a);
    b_ext  = signed_mode ? PW'(signed'(b)) : PW'(b);
    p_full = a_ext * b_ext;
    prod   = signed_mode ? W'(signed'(p_full)) : W'(p_full);
  end

  always_comb begin
    t_acc  = use_acc  ? ext(acc, signed_mode)  : '0;
    t_prod = ext(prod_reg, signed_mode);
    t_casc = use_casc ? ext(casc, signed_mode) : '0;
    total  = t_acc + t_prod + t_casc;
    top    = total[SW-1:W-1];
    ovf    = signed_mode ? !((top == 3'b000) || (top == 3'b111))
                         : (top[2:1] != 2'b00);
    sum    = total[W-1:0];
    if (sat && ovf) begin
      if (signed_mode && total[SW-1]) sum = W'(sat_min(W, 1'b1));
      else                            sum = W'(sat_max(W, signed_mode));
    end
  end

endmodule

// File: rtl/dsp_mac_cascade.sv
// Pipelined MAC slice: optional input register, product register and
// accumulator with cascade add, saturation and a dual-lane SIMD mode.
module dsp_mac_cascade
  import dsp_pkg::*;
#(
  parameter int A_WIDTH      = 8,
  parameter int B_WIDTH      = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int NoConfigBits = 6
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic [NoConfigBits-1:0] ConfigBits,
  dsp_mac_cascade_if.slave        bus
);

  localparam int HA = A_WIDTH / 2;
  localparam int HB = B_WIDTH / 2;
  localparam int HW = ACC_WIDTH / 2;

  logic cfg_inreg, cfg_signed, cfg_acc, cfg_casc, cfg_sat, cfg_simd;
  assign cfg_inreg  = ConfigBits[CFG_INREG];
  assign cfg_signed = ConfigBits[CFG_SIGNED];
  assign cfg_acc    = ConfigBits[CFG_ACC];
  assign cfg_casc   = ConfigBits[CFG_CASC];
  assign cfg_sat    = ConfigBits[CFG_SAT];
  assign cfg_simd   = ConfigBits[CFG_SIMD];

  logic [A_WIDTH-1:0]   a_q, a_s1;
  logic [B_WIDTH-1:0]   b_q, b_s1;
  logic                 v1_q, c1_q, v_s1, c_s1;
  logic [ACC_WIDTH-1:0] prod_q, acc_q;
  logic                 v2_q, c2_q, vout_q, ovf_q;

  // S1 stage: registered copy, or the raw inputs when the register is bypassed.
  assign a_s1 = cfg_inreg ? a_q  : bus.A;
  assign b_s1 = cfg_inreg ? b_q  : bus.B;
  assign v_s1 = cfg_inreg ? v1_q : bus.valid_in;
  assign c_s1 = cfg_inreg ? c1_q : bus.clr;

  logic                 use_acc;
  logic [ACC_WIDTH-1:0] full_prod, full_sum;
  logic [HW-1:0]        lo_prod, hi_prod, lo_sum, hi_sum;
  logic                 full_ovf, lo_ovf, hi_ovf;
  logic [ACC_WIDTH-1:0] prod_sel, acc_next;
  logic                 ovf_next;

  assign use_acc = cfg_acc & ~c2_q;

  dsp_mac_lane #(.AW(A_WIDTH), .BW(B_WIDTH), .W(ACC_WIDTH)) u_full (
    .signed_mode(cfg_signed), .a(a_s1), .b(b_s1), .prod(full_prod),
    .prod_reg(prod_q), .acc(acc_q), .casc(bus.casc_in),
    .use_acc(use_acc), .use_casc(cfg_casc), .sat(cfg_sat),
    .sum(full_sum), .ovf(full_ovf)
  );

  dsp_mac_lane #(.AW(HA), .BW(HB), .W(HW)) u_lo (
    .signed_mode(cfg_signed), .a(a_s1[HA-1:0]), .b(b_s1[HB-1:0]), .prod(lo_prod),
    .prod_reg(prod_q[HW-1:0]), .acc(acc_q[HW-1:0]), .casc(bus.casc_in[HW-1:0]),
    .use_acc(use_acc), .use_casc(cfg_casc), .sat(cfg_sat),
    .sum(lo_sum), .ovf(lo_ovf)
  );

  dsp_mac_lane #(.AW(A_WIDTH - HA), .BW(B_WIDTH - HB), .W(ACC_WIDTH - HW)) u_hi (
    .signed_mode(cfg_signed), .a(a_s1[A_WIDTH-1:HA]), .b(b_s1[B_WIDTH-1:HB]), .prod(hi_prod),
    .prod_reg(prod_q[ACC_WIDTH-1:HW]), .acc(acc_q[ACC_WIDTH-1:HW]),
    .casc(bus.casc_in[ACC_WIDTH-1:HW]),
    .use_acc(use_acc), .use_casc(cfg_casc), .sat(cfg_sat),
    .sum(hi_sum), .ovf(hi_ovf)
  );

  assign prod_sel = cfg_simd ? {hi_prod, lo_prod} : full_prod;
  assign acc_next = cfg_simd ? {hi_sum, lo_sum}   : full_sum;
  assign ovf_next = cfg_simd ? (hi_ovf | lo_ovf)  : full_ovf;

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      c1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
      c2_q   <= 1'b0;
      acc_q  <= '0;
      vout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.ce) begin
      a_q    <= bus.A;
      b_q    <= bus.B;
      v1_q   <= bus.valid_in;
      c1_q   <= bus.clr;
      prod_q <= prod_sel;
      v2_q   <= v_s1;
      c2_q   <= c_s1;
      vout_q <= v2_q;
      // A clr beat restarts the sticky flag from its own overflow status.
      if (v2_q) begin
        acc_q <= acc_next;
        ovf_q <= ovf_next | (ovf_q & ~c2_q);
      end else if (c2_q) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.Q         = acc_q;
  assign bus.casc_out  = acc_q;
  assign bus.valid_out = vout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_dsp_mac_cascade.sv
// Directed bench for dsp_mac_cascade: hand-computed results go into an
// expected queue; a monitor pops and compares on every new valid_out.
module tb_dsp_mac_cascade;
  import dsp_pkg::*;

  localparam int AW = 8;
  localparam int BW = 8;
  localparam int W  = 20;

  logic       UserCLK = 1'b0;
  logic       Reset;
  logic [5:0] ConfigBits;

  dsp_mac_cascade_if #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(W)) bus ();

  dsp_mac_cascade #(.A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(W), .NoConfigBits(6)) dut (
    .UserCLK   (UserCLK),
    .Reset     (Reset),
    .ConfigBits(ConfigBits),
    .bus       (bus.slave)
  );

  // ---------------- clock / cycle count ----------------
  always #5 UserCLK = ~UserCLK;

  int cyc = 0;
  always @(posedge UserCLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W:0] exp_q[$];      // {overflow, Q}
  int         exp_cyc_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input string tag, input logic c, input logic [7:0] a, input logic [7:0] b,
                      input logic [W-1:0] eq, input logic eo, input int extra, input bit push);
    @(negedge UserCLK);
    bus.valid_in = 1'b1;
    bus.clr      = c;
    bus.A        = a;
    bus.B        = b;
    if (push) begin
      exp_q.push_back({eo, eq});
      exp_cyc_q.push_back(cyc + (ConfigBits[CFG_INREG] ? 3 : 2) + extra);
      tag_q.push_back(tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge UserCLK);
      bus.valid_in = 1'b0;
      bus.clr      = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge UserCLK);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
      tag_q.delete();
    end
    idle(2);
  endtask

  // ---------------- monitor ----------------
  logic       mon_adv;
  logic [W:0] mon_got, mon_exp;
  int         mon_cyc;
  string      mon_tag;

  initial begin
    forever begin
      @(posedge UserCLK);
      mon_adv = bus.ce && !Reset;
      @(negedge UserCLK);
      if (mon_adv && bus.valid_out) begin
        mon_got = {bus.overflow, bus.Q};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid_out: got Q=0x%0h ovf=%0b at cycle %0d, expected no result",
                   bus.Q, bus.overflow, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          mon_tag = tag_q.pop_front();
          check({mon_tag, "_q_ovf"}, 32'(mon_got), 32'(mon_exp));
          check({mon_tag, "_cycle"}, cyc, mon_cyc);
          check({mon_tag, "_casc_out"}, 32'(bus.casc_out), 32'(mon_exp[W-1:0]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset        = 1'b1;
    ConfigBits   = 6'b000001;
    bus.ce       = 1'b1;
    bus.valid_in = 1'b0;
    bus.clr      = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.casc_in  = '0;

    // Reset state, with random traffic applied while held in reset
    repeat (4) begin
      @(negedge UserCLK);
      bus.valid_in = 1'($urandom_range(0, 1));
      bus.A        = 8'($urandom_range(0, 255));
      bus.B        = 8'($urandom_range(0, 255));
    end
    check("reset_q", 32'(bus.Q), 0);
    check("reset_casc_out", 32'(bus.casc_out), 0);
    check("reset_valid_out", 32'(bus.valid_out), 0);
    check("reset_overflow", 32'(bus.overflow), 0);
    @(negedge UserCLK);
    Reset        = 1'b0;
    bus.valid_in = 1'b0;
    idle(2);

    // Unsigned multiply, input register on (3 cycles) and off (2 cycles)
    send("mul_inreg", 1'b1, 8'd12, 8'd10, 20'd120, 1'b0, 0, 1'b1);
    drain();
    ConfigBits = 6'b000000;
    send("mul_bypass", 1'b1, 8'd12, 8'd10, 20'd120, 1'b0, 0, 1'b1);
    drain();

    // Signed accumulate: -3*5 four times
    ConfigBits = 6'b000111;
    send("sacc1", 1'b1, 8'hFD, 8'd5, 20'hFFFF1, 1'b0, 0, 1'b1);
    send("sacc2", 1'b0, 8'hFD, 8'd5, 20'hFFFE2, 1'b0, 0, 1'b1);
    send("sacc3", 1'b0, 8'hFD, 8'd5, 20'hFFFD3, 1'b0, 0, 1'b1);
    send("sacc4", 1'b0, 8'hFD, 8'd5, 20'hFFFC4, 1'b0, 0, 1'b1);
    drain();

    // Unsigned saturation, sticky flag, clearing clr beat
    ConfigBits = 6'b010101;
    for (int k = 1; k <= 16; k++)
      send("sat_acc", (k == 1), 8'd255, 8'd255, 20'(65025 * k), 1'b0, 0, 1'b1);
    send("sat_clamp", 1'b0, 8'd255, 8'd255, 20'hFFFFF, 1'b1, 0, 1'b1);
    send("sat_sticky", 1'b0, 8'd0, 8'd0, 20'hFFFFF, 1'b1, 0, 1'b1);
    send("sat_clr", 1'b1, 8'd1, 8'd1, 20'd1, 1'b0, 0, 1'b1);
    drain();

    // SIMD lanes: unsigned, no carry across lanes, signed, per-lane saturation
    ConfigBits = 6'b100001;
    send("simd_a", 1'b1, 8'h23, 8'h45, 20'd8207, 1'b0, 0, 1'b1);
    send("simd_b", 1'b1, 8'hF0, 8'hF0, 20'd230400, 1'b0, 0, 1'b1);
    drain();
    ConfigBits = 6'b100011;
    send("simd_signed", 1'b1, 8'hFF, 8'h13, 20'hFFFFD, 1'b0, 0, 1'b1);
    drain();
    ConfigBits  = 6'b111001;
    bus.casc_in = 20'hFFC01;
    send("simd_sat", 1'b1, 8'h11, 8'h11, 20'hFFC02, 1'b1, 0, 1'b1);
    drain();

    // Cascade add, wrap without saturation, then a clean clr beat
    ConfigBits  = 6'b001001;
    bus.casc_in = 20'd1000;
    send("casc", 1'b1, 8'd2, 8'd3, 20'd1006, 1'b0, 0, 1'b1);
    drain();
    bus.casc_in = 20'hFFFFF;
    send("casc_wrap", 1'b1, 8'd2, 8'd3, 20'd5, 1'b1, 0, 1'b1);
    drain();
    bus.casc_in = 20'd0;
    send("casc_clr", 1'b1, 8'd1, 8'd1, 20'd1, 1'b0, 0, 1'b1);
    drain();

    // Signed saturation at both ends of the range
    ConfigBits  = 6'b011011;
    bus.casc_in = 20'h7FFFF;
    send("ssat_max", 1'b1, 8'd1, 8'd1, 20'h7FFFF, 1'b1, 0, 1'b1);
    drain();
    bus.casc_in = 20'h80000;
    send("ssat_min", 1'b1, 8'hFF, 8'd1, 20'h80000, 1'b1, 0, 1'b1);
    drain();
    bus.casc_in = 20'd0;

    // Stall: ce low for two cycles while beats are in flight
    ConfigBits = 6'b000001;
    send("stall1", 1'b1, 8'd3, 8'd4, 20'd12, 1'b0, 0, 1'b1);
    send("stall2", 1'b1, 8'd5, 8'd6, 20'd30, 1'b0, 2, 1'b1);
    send("stall3", 1'b1, 8'd7, 8'd8, 20'd56, 1'b0, 2, 1'b1);
    @(negedge UserCLK);
    bus.ce       = 1'b0;
    bus.valid_in = 1'b0;
    bus.clr      = 1'b0;
    repeat (2) begin
      @(negedge UserCLK);
      check("stall_hold_valid", 32'(bus.valid_out), 1);
      check("stall_hold_q", 32'(bus.Q), 12);
    end
    bus.ce = 1'b1;
    drain();

    // Reset mid-stream flushes in-flight beats and the sticky flag
    ConfigBits  = 6'b011101;
    bus.casc_in = 20'hFFFFF;
    send("pre_reset", 1'b1, 8'd1, 8'd1, 20'hFFFFF, 1'b1, 0, 1'b1);
    send("flushed_a", 1'b0, 8'd2, 8'd2, 20'd0, 1'b0, 0, 1'b0);
    send("flushed_b", 1'b0, 8'd3, 8'd3, 20'd0, 1'b0, 0, 1'b0);
    @(negedge UserCLK);
    Reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.clr      = 1'b0;
    @(negedge UserCLK);
    check("midrst_q", 32'(bus.Q), 0);
    check("midrst_valid_out", 32'(bus.valid_out), 0);
    check("midrst_overflow", 32'(bus.overflow), 0);
    Reset = 1'b0;
    repeat (6) begin
      @(negedge UserCLK);
      check("post_reset_quiet", 32'(bus.valid_out), 0);
    end
    bus.casc_in = 20'd0;
    send("post_reset", 1'b1, 8'd2, 8'd3, 20'd6, 1'b0, 0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
